// File: rtl/fetch_controller_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_controller_if : PC, instruction-memory and decode bundle
// Rev 1.0
// ------------------------------------------------------------------
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] currentAddress;
  logic [ADDR_WIDTH-1:0] nextAddress;
  logic                  imemReq;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic                  imemAck;
  logic [DATA_WIDTH-1:0] imemData;
  logic                  instrValid;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] instrAddr;
  logic                  instrReady;
  logic                  redirectValid;
  logic [ADDR_WIDTH-1:0] redirectTarget;

  modport master (
    input  currentAddress, imemAck, imemData, instrReady, redirectValid, redirectTarget,
    output nextAddress, imemReq, imemAddr, instrValid, instruction, instrAddr
  );

  modport slave (
    output currentAddress, imemAck, imemData, instrReady, redirectValid, redirectTarget,
    input  nextAddress, imemReq, imemAddr, instrValid, instruction, instrAddr
  );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_controller : PC sequencer and instruction-fetch handshake
// Rev 1.0
// ------------------------------------------------------------------
module fetch_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  fetch_controller_if.master  io_fc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instruction;
  logic [ADDR_WIDTH-1:0] r_instr_addr;
  logic [ADDR_WIDTH-1:0] r_pending;
  logic [ADDR_WIDTH-1:0] w_pending_nxt;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_pc4;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_capture;

  assign w_pc4    = io_fc.currentAddress + ADDR_WIDTH'(4);
  assign w_target = {io_fc.redirectTarget[ADDR_WIDTH-1:2], 2'b00};

  // The PC reloads every edge, so "stay" always means recirculating currentAddress.
  always_comb begin
    w_state_nxt   = r_state;
    w_next_addr   = io_fc.currentAddress;
    w_pending_nxt = r_pending;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (io_fc.redirectValid) w_next_addr = w_target;
      end
      S_FETCH: begin
        if (io_fc.imemAck) begin
          if (io_fc.redirectValid) begin
            w_next_addr = w_target;
          end else begin
            w_next_addr = w_pc4;
            w_capture   = 1'b1;
            w_state_nxt = S_OUT;
          end
        end else if (io_fc.redirectValid) begin
          w_pending_nxt = w_target;
          w_state_nxt   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (io_fc.redirectValid) w_pending_nxt = w_target;
        if (io_fc.imemAck) begin
          w_next_addr = io_fc.redirectValid ? w_target : r_pending;
          w_state_nxt = S_FETCH;
        end
      end
      S_OUT: begin
        if (io_fc.redirectValid) begin
          w_next_addr = w_target;
          w_state_nxt = S_FETCH;
        end else if (io_fc.instrReady) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) w_next_addr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_valid       <= 1'b0;
      r_instruction <= '0;
      r_instr_addr  <= '0;
      r_pending     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= (w_state_nxt == S_OUT);
      r_pending <= w_pending_nxt;
      if (w_capture) begin
        r_instruction <= io_fc.imemData;
        r_instr_addr  <= io_fc.currentAddress;
      end
    end
  end

  assign io_fc.nextAddress = w_next_addr;
  assign io_fc.imemReq     = !rst && ((r_state == S_FETCH) || (r_state == S_DRAIN));
  assign io_fc.imemAddr    = io_fc.currentAddress;
  assign io_fc.instrValid  = r_valid;
  assign io_fc.instruction = r_instruction;
  assign io_fc.instrAddr   = r_instr_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_controller : directed bench with PC register, memory model
// and a scoreboard of accepted instructions. Rev 1.0
// ------------------------------------------------------------------
module tb_fetch_controller;

  localparam int AW = 12;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mem_delay;
  int   wait_cnt;
  logic [DW+AW-1:0] sb[$];

  fetch_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fc ();

  fetch_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_fc (fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == '0) return 32'h2008_0005;
    return 32'hA000_0000 | {20'd0, a};
  endfunction

  // PC register and a memory that acks after mem_delay waiting cycles
  always @(posedge clk) fc.currentAddress <= fc.nextAddress;
  always @(posedge clk) begin
    if (rst || !fc.imemReq || fc.imemAck) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign fc.imemAck  = fc.imemReq && (wait_cnt == mem_delay);
  assign fc.imemData = mem_word(fc.imemAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && fc.instrValid && fc.instrReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual addr=%h instr=%h required=none", fc.instrAddr, fc.instruction);
      end else begin
        logic [DW+AW-1:0] e;
        e = sb.pop_front();
        chk("sb_instr", fc.instruction, e[DW+AW-1:AW]);
        chk("sb_addr", {20'd0, fc.instrAddr}, {20'd0, e[AW-1:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mem_delay = 0;
    fc.instrReady = 1'b1;
    fc.redirectValid = 1'b0;
    fc.redirectTarget = '0;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_valid", {31'd0, fc.instrValid}, 32'd0);
    chk("rst_instr", fc.instruction, 32'd0);
    chk("rst_iaddr", {20'd0, fc.instrAddr}, 32'd0);
    chk("rst_next", {20'd0, fc.nextAddress}, 32'd0);
    chk("rst_req", {31'd0, fc.imemReq}, 32'd0);

    // zero-wait memory, decode always ready
    sb.push_back({32'h2008_0005, 12'h000});
    sb.push_back({32'hA000_0004, 12'h004});
    step(); rst = 1'b0;
    sample();
    chk("idle_req", {31'd0, fc.imemReq}, 32'd0);
    chk("idle_next", {20'd0, fc.nextAddress}, 32'd0);
    step(); sample();
    chk("f0_req", {31'd0, fc.imemReq}, 32'd1);
    chk("f0_addr", {20'd0, fc.imemAddr}, 32'h000);
    chk("f0_next", {20'd0, fc.nextAddress}, 32'h004);
    step(); sample();
    chk("o0_valid", {31'd0, fc.instrValid}, 32'd1);
    chk("o0_pc", {20'd0, fc.currentAddress}, 32'h004);
    chk("o0_req", {31'd0, fc.imemReq}, 32'd0);
    step(); sample();
    chk("f4_addr", {20'd0, fc.imemAddr}, 32'h004);
    step(); mem_delay = 3; sample();
    chk("o4_pc", {20'd0, fc.currentAddress}, 32'h008);

    // three-cycle memory latency at 0x008
    sb.push_back({32'hA000_0008, 12'h008});
    for (int i = 0; i < 3; i++) begin
      step(); sample();
      chk("wait_req", {31'd0, fc.imemReq}, 32'd1);
      chk("wait_addr", {20'd0, fc.imemAddr}, 32'h008);
      chk("wait_next", {20'd0, fc.nextAddress}, 32'h008);
    end
    step(); sample();
    chk("ack_next", {20'd0, fc.nextAddress}, 32'h00C);

    // decode stalls for four cycles
    step(); fc.instrReady = 1'b0; mem_delay = 0;
    sample();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin step(); sample(); end
      chk("stall_valid", {31'd0, fc.instrValid}, 32'd1);
      chk("stall_instr", fc.instruction, 32'hA000_0008);
      chk("stall_iaddr", {20'd0, fc.instrAddr}, 32'h008);
      chk("stall_pc", {20'd0, fc.currentAddress}, 32'h00C);
      chk("stall_req", {31'd0, fc.imemReq}, 32'd0);
    end
    sb.push_back({32'hA000_000C, 12'h00C});
    step(); fc.instrReady = 1'b1; sample();
    step(); sample();
    chk("fC_next", {20'd0, fc.nextAddress}, 32'h010);
    step(); mem_delay = 2; sample();
    chk("oC_pc", {20'd0, fc.currentAddress}, 32'h010);

    // redirect to 0x203 while the 0x010 fetch is outstanding
    step(); fc.redirectValid = 1'b1; fc.redirectTarget = 12'h203; sample();
    chk("drq_next", {20'd0, fc.nextAddress}, 32'h010);
    chk("drq_req", {31'd0, fc.imemReq}, 32'd1);
    step(); fc.redirectValid = 1'b0; sample();
    chk("drain_pc", {20'd0, fc.currentAddress}, 32'h010);
    chk("drain_addr", {20'd0, fc.imemAddr}, 32'h010);
    chk("drain_valid", {31'd0, fc.instrValid}, 32'd0);
    step(); sample();
    chk("drain_ack_next", {20'd0, fc.nextAddress}, 32'h200);
    chk("drain_ack_valid", {31'd0, fc.instrValid}, 32'd0);
    sb.push_back({32'hA000_0200, 12'h200});
    step(); mem_delay = 0; sample();
    chk("rd_pc", {20'd0, fc.currentAddress}, 32'h200);
    chk("rd_req", {31'd0, fc.imemReq}, 32'd1);

    // redirect to 0x100 in OUT, with the transfer accepted the same cycle
    step(); fc.redirectValid = 1'b1; fc.redirectTarget = 12'h100; sample();
    chk("ro_next", {20'd0, fc.nextAddress}, 32'h100);
    step(); fc.redirectTarget = 12'hFFC; sample();
    chk("ro_valid", {31'd0, fc.instrValid}, 32'd0);
    chk("ro_pc", {20'd0, fc.currentAddress}, 32'h100);
    chk("ro_addr", {20'd0, fc.imemAddr}, 32'h100);
    chk("ackredir_next", {20'd0, fc.nextAddress}, 32'hFFC);

    // wrap of PC+4 at the top of the address space
    sb.push_back({32'hA000_0FFC, 12'hFFC});
    step(); fc.redirectValid = 1'b0; sample();
    chk("wrap_next", {20'd0, fc.nextAddress}, 32'h000);
    step(); mem_delay = 1000; sample();
    chk("wrap_valid", {31'd0, fc.instrValid}, 32'd1);
    chk("wrap_pc", {20'd0, fc.currentAddress}, 32'h000);
    repeat (3) begin step(); sample(); end
    chk("park_valid", {31'd0, fc.instrValid}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer that closes the loop around the program counter. It consumes `currentAddress` from the PC register and issues a request/acknowledge read to instruction memory. It holds the returned word for the decode stage under a valid/ready handshake and drives `nextAddress` back into the PC: hold, PC+4, or redirect target. Since the PC loads every clock, all stalling is done by recirculating `currentAddress`.

## Interface
- `ADDR_WIDTH`, 12: byte-address width of PC and instruction memory.
- `DATA_WIDTH`, 32: instruction word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `currentAddress` in ADDR_WIDTH: PC register output.
- `nextAddress` out ADDR_WIDTH: PC register input, combinational.
- `imemReq` out 1: instruction-memory read request.
- `imemAddr` out ADDR_WIDTH: request address, always equal to `currentAddress`.
- `imemAck` in 1: read complete; `imemData` valid this cycle.
- `imemData` in DATA_WIDTH: returned instruction.
- `instrValid` out 1: `instruction`/`instrAddr` valid to decode.
- `instruction` out DATA_WIDTH: held instruction word.
- `instrAddr` out ADDR_WIDTH: address the held instruction was fetched from.
- `instrReady` in 1: decode accepts the instruction.
- `redirectValid` in 1: branch/jump taken, one-cycle pulse.
- `redirectTarget` in ADDR_WIDTH: redirect address; bits [1:0] are forced to 0 internally.

## Operation
- Registered state:
  - FSM: IDLE, FETCH, DRAIN, OUT.
  - `instruction`, `instrAddr`, `instrValid`.
  - `pendingTarget`.
- `PC4 = currentAddress + 4`, truncated to ADDR_WIDTH (wraps).
- `imemReq = 1` in FETCH and DRAIN only.
- `instrValid = 1` in OUT only.
- IDLE:
  - `nextAddress = currentAddress`.
  - Unconditionally go to FETCH. A redirect in this cycle loads its target into the PC and still goes to FETCH.
- FETCH:
  - No ack, no redirect: `nextAddress = currentAddress`, stay.
  - No ack, redirect: latch `pendingTarget = redirectTarget`, `nextAddress = currentAddress`, go to DRAIN. The outstanding request must complete first.
  - Ack, no redirect: capture `imemData` into `instruction` and `currentAddress` into `instrAddr`, `nextAddress = PC4`, go to OUT.
  - Ack and redirect: discard data, `nextAddress = redirectTarget`, stay in FETCH.
- DRAIN:
  - `imemReq` held with unchanged address.
  - A further redirect overwrites `pendingTarget`.
  - On ack: discard data. `nextAddress = redirectTarget` if `redirectValid` this cycle, else `pendingTarget`. Go to FETCH.
  - Without ack: `nextAddress = currentAddress`.
- OUT:
  - PC already advanced; `nextAddress = currentAddress`.
  - Redirect: `nextAddress = redirectTarget`, go to FETCH, `instrValid` low next cycle. If `instrReady` is high in the same cycle, the transfer still counts as accepted.
  - `instrReady` with no redirect: go to FETCH.
  - Otherwise hold; `instruction` and `instrAddr` stay stable.
- Memory protocol: while `imemReq` is high, `imemAddr` stays stable until `imemAck`. `imemReq` may stay high across back-to-back requests with a new address after an ack. `imemAck` outside a request is ignored.

## Timing
- Reset, while `rst` is high:
  - State goes to IDLE.
  - `instrValid = 0`, `instruction = 0`, `instrAddr = 0`, `pendingTarget = 0`.
  - `nextAddress = 0` combinationally; `imemReq = 0`.
- Reset mid-operation abandons any outstanding request and any held instruction.
- First request is issued two cycles after `rst` deasserts: IDLE for one cycle, then FETCH.
- Zero-wait memory (ack in the request cycle): `instrValid` is high the cycle after the request.
- Throughput: at best one instruction every 2 cycles (FETCH then OUT with `instrReady` high).
- Redirect latency: the PC holds the target one edge after the redirect cycle. The exception is DRAIN, where the PC loads the target on the edge after the ack.
- `nextAddress`, `imemReq` and `imemAddr` are combinational from state, `currentAddress` and inputs. No path runs from `imemData` to `nextAddress`.

## Test plan
- Reset then zero-wait memory returning `0x20080005` at 0x000 with `instrReady` held at 1:
  - First `imemReq` appears 2 cycles after reset release.
  - `instrValid` rises with `instruction = 0x20080005`, `instrAddr = 0x000`.
  - The PC sequence is 0x000, 0x004, 0x008, advancing every 2 cycles.
- Memory ack delayed 3 cycles:
  - `imemReq` and `imemAddr` stay stable for 3 cycles.
  - `nextAddress` equals `currentAddress` until the ack, then PC+4.
- `instrReady = 0` for 4 cycles in OUT:
  - `instruction` and `instrAddr` stay stable.
  - PC holds at `instrAddr + 4`; no new request is issued.
- Redirect to 0x100 in OUT:
  - `instrValid` drops next cycle.
  - PC becomes 0x100; next fetch is issued at 0x100.
- Redirect to 0x203 while FETCH waits at 0x010, ack 2 cycles later:
  - PC stays at 0x010 through the ack.
  - Data is discarded, `instrValid` never rises.
  - PC becomes 0x200 (low bits forced to 0).
- PC at 0xFFC with ADDR_WIDTH = 12: ack → `nextAddress = 0x000` (wrap).
